saph_fpu_dispatch: RTL and testbench
====================================

# saph_fpu_dispatch

Issue and collect stage placed directly upstream of a single FPU computation unit. It accepts tagged floating-point requests from the shader core over a valid/ready handshake and issues them to the FPU, which has fixed latency and cannot stall. In-flight tags are tracked in a shift pipeline matched to the FPU latency. Results are collected into an output FIFO whose space is reserved at issue time, so FPU results are never dropped.

## Interface
Parameters:
- `LATENCY`, 2: FPU latency in cycles, 0..4; must equal the attached unit's latency.
- `DEPTH`, 4: result FIFO entries, 2..16, with DEPTH ≥ LATENCY+1.
- `TAG_W`, 4: request tag width.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_mode` in 2: operation; 00 add, 01 sub, 10 mul, 11 div.
- `req_lhs` / `req_rhs` in 32: binary32 operands.
- `req_tag` in TAG_W: returned unchanged with the response.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_res` out 32: result.
- `rsp_tag` out TAG_W: tag of the response.
- `rsp_err` out 1: mode not supported by the FPU.
- `fpu_d_trig` out 1: issue strobe.
- `fpu_d_mode` out 2: mode to the FPU.
- `fpu_d_lhs` / `fpu_d_rhs` out 32: operands to the FPU.
- `fpu_d_ready` in 1: FPU able to accept.
- `fpu_has_modes` in 4: supported modes, ordered {div, mul, sub, add}.
- `fpu_q_trig` in 1: FPU result strobe.
- `fpu_q_res` in 32: FPU result.
- `proto_err` out 1: sticky flag for a result-strobe mismatch.
- `used` out $clog2(DEPTH+1): FIFO entries plus in-flight operations.

## Operation
- **Accept:** `acc = req_valid && req_ready`.
- **Ready:** `req_ready = rst_n && fpu_d_ready && (used < DEPTH)`. The `used` term is registered, so a pop in the same cycle does not free a credit until the next cycle.
- **Supported check:** `sup = fpu_has_modes[req_mode]`.
- **FPU drive:**
  - `fpu_d_trig = acc && sup`.
  - `fpu_d_mode`, `fpu_d_lhs` and `fpu_d_rhs` pass `req_*` through combinationally.
- **Tag pipeline:** LATENCY stages, each holding {v, tag, err}.
  - Stage 0 loads {acc, req_tag, !sup}.
  - Each stage shifts every cycle, without stalling.
  - When LATENCY = 0, the stage-0 value is used combinationally in the same cycle.
- **Collect:** when the last stage has v = 1, push {tag, err ? 32'h0 : fpu_q_res, err} into the FIFO.
  - Unsupported requests therefore complete in order, with no FPU issue.
- **Result check:** expected strobe = last-stage (v && !err).
  - If `fpu_q_trig` differs from the expected strobe, set `proto_err`. It stays high until reset.
  - Result data is pushed regardless.
- **Output FIFO:** registered head.
  - `rsp_valid` = FIFO not empty.
  - A pop occurs on `rsp_valid && rsp_ready`.
- **Occupancy:** `used` next = used + acc − pop.
  - Push never overflows, by construction.
  - Simultaneous push and pop on a full FIFO is legal.
- **Pointers:** read and write pointers wrap modulo DEPTH. A separate count distinguishes full from empty.

## Timing
- **Reset** (`rst_n` low at a clock edge):
  - FIFO emptied, `used` = 0, all pipeline v = 0, `proto_err` = 0.
  - `rsp_valid` = 0, `req_ready` = 0, `fpu_d_trig` = 0.
  - `rsp_res`, `rsp_tag` and `rsp_err` read 0.
- **Reset mid-operation:** in-flight operations are discarded. FPU results arriving after reset are ignored and do not raise `proto_err`.
- **Latency:** accept at cycle 0 → push at cycle LATENCY → `rsp_valid` at cycle LATENCY+1. With the default this is cycle 3.
- **Throughput:** one request per cycle while credits remain.
- **Order:** responses return in acceptance order.
- **Full:** when `used` = DEPTH, `req_ready` = 0. It rises the cycle after the first pop.
- **FPU busy:** when `fpu_d_ready` = 0, `req_ready` = 0 and no issue occurs.
- **Response hold:** `rsp_*` stays stable while `rsp_valid && !rsp_ready`.

## Test plan
- **Add, default params, has_modes = 4'b1111:**
  - Stimulus: mode 00, lhs 0x3F800000, rhs 0x40000000, tag 5.
  - Required: `rsp_valid` at cycle 3 with res 0x40400000, tag 5, err 0.
- **Back-to-back issue:**
  - Stimulus: mul 0x40400000 × 0x40000000 (tag 1), then div 0x3F800000 / 0x40000000 (tag 2), on consecutive cycles.
  - Required: responses 0x40C00000/1 then 0x3F000000/2 on consecutive cycles; `fpu_d_trig` high for both issue cycles.
- **Unsupported mode:**
  - Stimulus: has_modes = 4'b0011, issue div (tag 3) between two adds.
  - Required: no `fpu_d_trig` for the div; responses in order, with the div returning res 0, err 1.
- **Backpressure:**
  - Stimulus: `rsp_ready` = 0, stream requests.
  - Required: exactly 4 accepted, `req_ready` low while `used` = 4. Raise `rsp_ready` for one cycle → `req_ready` high the following cycle, with no response lost or duplicated.
- **Protocol error:**
  - Stimulus: model drops `fpu_q_trig` for one expected result.
  - Required: `proto_err` rises at that cycle and stays high; the response is still delivered.
- **Reset mid-flight:**
  - Stimulus: 2 requests issued, `rst_n` low one cycle after.
  - Required: no responses, `used` = 0, `proto_err` = 0 after reset; a new request completes normally in LATENCY+1 cycles.

Source files
------------

// File: rtl/saph_fpu_dispatch.sv
// Issue/collect stage in front of a fixed-latency, non-stalling FPU.
// Result FIFO space is reserved at issue, so completions are never dropped.
module saph_fpu_dispatch #(
  parameter  int LATENCY = 2,
  parameter  int DEPTH   = 4,
  parameter  int TAG_W   = 4,
  localparam int UW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [31:0]      req_lhs,
  input  logic [31:0]      req_rhs,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_res,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             fpu_d_trig,
  output logic [1:0]       fpu_d_mode,
  output logic [31:0]      fpu_d_lhs,
  output logic [31:0]      fpu_d_rhs,
  input  logic             fpu_d_ready,
  input  logic [3:0]       fpu_has_modes,
  input  logic             fpu_q_trig,
  input  logic [31:0]      fpu_q_res,
  output logic             proto_err,
  output logic [UW-1:0]    used
);

  logic             w_acc;
  logic             w_sup;
  logic             w_pop;
  logic             w_lv;
  logic [TAG_W-1:0] w_ltag;
  logic             w_lerr;
  logic             w_exp;

  logic [UW-1:0]    r_used;
  logic [UW-1:0]    r_cnt;
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic             r_proto;
  logic [2:0]       r_quiet;

  logic [TAG_W-1:0] r_mtag [DEPTH];
  logic [31:0]      r_mres [DEPTH];
  logic             r_merr [DEPTH];

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready  = rst_n && fpu_d_ready && (r_used < UW'(DEPTH));
  assign w_acc      = req_valid && req_ready;
  assign w_sup      = fpu_has_modes[req_mode];
  assign fpu_d_trig = w_acc && w_sup;
  assign fpu_d_mode = req_mode;
  assign fpu_d_lhs  = req_lhs;
  assign fpu_d_rhs  = req_rhs;

  generate
    if (LATENCY == 0) begin : g_comb
      assign w_lv   = w_acc;
      assign w_ltag = req_tag;
      assign w_lerr = !w_sup;
    end else begin : g_pipe
      logic [LATENCY-1:0] r_pv;
      logic [LATENCY-1:0] r_perr;
      logic [TAG_W-1:0]   r_ptag [LATENCY];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_pv   <= '0;
          r_perr <= '0;
          for (int i = 0; i < LATENCY; i++) r_ptag[i] <= '0;
        end else begin
          r_pv[0]   <= w_acc;
          r_ptag[0] <= req_tag;
          r_perr[0] <= !w_sup;
          for (int i = 1; i < LATENCY; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_ptag[i] <= r_ptag[i-1];
            r_perr[i] <= r_perr[i-1];
          end
        end
      end

      assign w_lv   = r_pv[LATENCY-1];
      assign w_ltag = r_ptag[LATENCY-1];
      assign w_lerr = r_perr[LATENCY-1];
    end
  endgenerate

  assign w_exp     = w_lv && !w_lerr;
  assign rsp_valid = (r_cnt != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_res   = rsp_valid ? r_mres[r_rp] : '0;
  assign rsp_tag   = rsp_valid ? r_mtag[r_rp] : '0;
  assign rsp_err   = rsp_valid ? r_merr[r_rp] : 1'b0;
  assign proto_err = r_proto;
  assign used      = r_used;

  always_ff @(posedge clk) begin
    if (rst_n && w_lv) begin
      r_mtag[r_wp] <= w_ltag;
      r_mres[r_wp] <= w_lerr ? 32'h0 : fpu_q_res;
      r_merr[r_wp] <= w_lerr;
    end
  end

  // r_quiet masks stale FPU strobes from ops issued before a reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_used  <= '0;
      r_proto <= 1'b0;
      r_quiet <= 3'(LATENCY);
    end else begin
      if (w_lv)  r_wp <= f_nxt(r_wp);
      if (w_pop) r_rp <= f_nxt(r_rp);
      r_cnt  <= r_cnt + UW'(w_lv) - UW'(w_pop);
      r_used <= r_used + UW'(w_acc) - UW'(w_pop);
      if (r_quiet != 3'd0) r_quiet <= r_quiet - 3'd1;
      if ((fpu_q_trig != w_exp) && ((r_quiet == 3'd0) || w_exp))
        r_proto <= 1'b1;
    end
  end

endmodule

// File: tb/tb_saph_fpu_dispatch.sv
// Self-checking bench for saph_fpu_dispatch with a behavioural FPU
// stand-in and a queue-based response scoreboard.
module tb_saph_fpu_dispatch;
  localparam int L = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_mode = 2'd0;
  logic [31:0] req_lhs = '0;
  logic [31:0] req_rhs = '0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        fpu_d_trig;
  logic [1:0]  fpu_d_mode;
  logic [31:0] fpu_d_lhs;
  logic [31:0] fpu_d_rhs;
  logic        fpu_d_ready = 1'b1;
  logic [3:0]  has = 4'hF;
  logic        fpu_q_trig;
  logic [31:0] fpu_q_res;
  logic        proto_err;
  logic [2:0]  used;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  saph_fpu_dispatch #(.LATENCY(L), .DEPTH(D), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .fpu_d_trig(fpu_d_trig), .fpu_d_mode(fpu_d_mode),
    .fpu_d_lhs(fpu_d_lhs), .fpu_d_rhs(fpu_d_rhs),
    .fpu_d_ready(fpu_d_ready), .fpu_has_modes(has),
    .fpu_q_trig(fpu_q_trig), .fpu_q_res(fpu_q_res),
    .proto_err(proto_err), .used(used)
  );

  // FPU stand-in: exact values for the directed vectors, a mix otherwise
  function automatic logic [31:0] fn(input logic [1:0] m,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (m == 2'd0 && a == 32'h3F800000 && b == 32'h40000000)
      return 32'h40400000;
    if (m == 2'd2 && a == 32'h40400000 && b == 32'h40000000)
      return 32'h40C00000;
    if (m == 2'd3 && a == 32'h3F800000 && b == 32'h40000000)
      return 32'h3F000000;
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, m};
  endfunction

  logic [L-1:0] m_v = '0;
  logic [31:0]  m_r [L];
  logic         m_drop = 1'b0;

  always @(posedge clk) begin
    m_v  <= {m_v[L-2:0], fpu_d_trig};
    m_r[1] <= m_r[0];
    m_r[0] <= fn(fpu_d_mode, fpu_d_lhs, fpu_d_rhs);
  end

  assign fpu_q_trig = m_v[L-1] && !m_drop;
  assign fpu_q_res  = m_r[L-1];

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
    req_valid = 1'b1;
    req_mode  = m;
    req_lhs   = a;
    req_rhs   = b;
    req_tag   = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'd0, 32'h1, 32'h2, 4'd1);
    step();
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL reset_req_ready got %b want 0", req_ready);
    end
    checks++;
    if (fpu_d_trig !== 1'b0) begin
      fails++; $display("FAIL reset_trig got %b want 0", fpu_d_trig);
    end
    checks++;
    if (used !== 3'd0) begin
      fails++; $display("FAIL reset_used got %0d want 0", used);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      fails++; $display("FAIL reset_proto got %b want 0", proto_err);
    end
    checks++;
    if ({rsp_res, rsp_tag, rsp_err} !== 37'd0) begin
      fails++;
      $display("FAIL reset_rsp_data got %h/%h/%b want 0",
               rsp_res, rsp_tag, rsp_err);
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_add();
    has = 4'hF;
    rsp_ready = 1'b1;
    drive(2'd0, 32'h3F800000, 32'h40000000, 4'd5);
    #1;
    checks++;
    if (fpu_d_trig !== 1'b1 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL add_issue got trig=%b rdy=%b want 1/1",
               fpu_d_trig, req_ready);
    end
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (rsp_valid !== (k == 3)) begin
        fails++;
        $display("FAIL add_latency c%0d got %b want %b", k, rsp_valid, k == 3);
      end
      if (k == 3) begin
        checks++;
        if ({rsp_res, rsp_tag, rsp_err} !== {32'h40400000, 4'd5, 1'b0}) begin
          fails++;
          $display("FAIL add_rsp got %h/%0d/%b want 40400000/5/0",
                   rsp_res, rsp_tag, rsp_err);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er [2];
    logic [3:0]  et [2];
    er[0] = 32'h40C00000; et[0] = 4'd1;
    er[1] = 32'h3F000000; et[1] = 4'd2;
    has = 4'hF;
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) drive(2'd2, 32'h40400000, 32'h40000000, 4'd1);
      else if (k == 1) drive(2'd3, 32'h3F800000, 32'h40000000, 4'd2);
      else req_valid = 1'b0;
      #1;
      if (k < 2) begin
        checks++;
        if (fpu_d_trig !== 1'b1) begin
          fails++; $display("FAIL b2b_trig c%0d got %b want 1", k, fpu_d_trig);
        end
      end
      if (k >= 3) begin
        checks++;
        if ({rsp_valid, rsp_res, rsp_tag, rsp_err} !==
            {1'b1, er[k-3], et[k-3], 1'b0}) begin
          fails++;
          $display("FAIL b2b_rsp c%0d got %b/%h/%0d want 1/%h/%0d",
                   k, rsp_valid, rsp_res, rsp_tag, er[k-3], et[k-3]);
        end
      end
      step();
    end
  endtask

  task automatic test_unsupported();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [1:0]  m [3];
    logic [3:0]  t [3];
    logic [31:0] er;
    has = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
    end
    m[0] = 2'd0; t[0] = 4'd6;
    m[1] = 2'd3; t[1] = 4'd3;
    m[2] = 2'd0; t[2] = 4'd7;
    for (int k = 0; k <= 5; k++) begin
      if (k < 3) drive(m[k], a[k], b[k], t[k]);
      else req_valid = 1'b0;
      #1;
      if (k < 3) begin
        checks++;
        if (fpu_d_trig !== (k != 1)) begin
          fails++;
          $display("FAIL unsup_trig c%0d got %b want %b", k, fpu_d_trig, k != 1);
        end
      end else begin
        er = (k == 4) ? 32'h0 : fn(2'd0, a[k-3], b[k-3]);
        checks++;
        if ({rsp_valid, rsp_res, rsp_tag, rsp_err} !==
            {1'b1, er, t[k-3], k == 4}) begin
          fails++;
          $display("FAIL unsup_rsp c%0d got %b/%h/%0d/%b want 1/%h/%0d/%b",
                   k, rsp_valid, rsp_res, rsp_tag, rsp_err, er, t[k-3], k == 4);
        end
      end
      step();
    end
    checks++;
    if (proto_err !== 1'b0) begin
      fails++; $display("FAIL unsup_proto got %b want 0", proto_err);
    end
    has = 4'hF;
  endtask

  task automatic test_backpressure();
    int n_acc;
    int nxt;
    n_acc = 0;
    has = 4'hF;
    rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(2'($urandom), $urandom, $urandom, 4'(n_acc));
      #1;
      if (used == 3'd4) begin
        checks++;
        if (req_ready !== 1'b0) begin
          fails++; $display("FAIL bp_full_ready got %b want 0", req_ready);
        end
      end
      if (req_valid && req_ready) n_acc++;
      step();
    end
    checks++;
    if (n_acc != 4 || used !== 3'd4) begin
      fails++;
      $display("FAIL bp_accepted got %0d used=%0d want 4/4", n_acc, used);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0) begin
      fails++;
      $display("FAIL bp_head got %b/%0d want 1/0", rsp_valid, rsp_tag);
    end
    step();
    rsp_ready = 1'b0;
    drive(2'd0, $urandom, $urandom, 4'd4);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL bp_credit got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    nxt = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (rsp_tag !== 4'(nxt)) begin
          fails++; $display("FAIL bp_order got %0d want %0d", rsp_tag, nxt);
        end
        nxt++;
      end
      step();
    end
    checks++;
    if (nxt != 5) begin
      fails++; $display("FAIL bp_count got %0d want 5", nxt - 1);
    end
  endtask

  task automatic test_proto_err();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    has = 4'hF;
    drive(2'd1, a, b, 4'd9);
    step();
    req_valid = 1'b0;
    step();
    m_drop = 1'b1;
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      fails++; $display("FAIL perr_early got %b want 0", proto_err);
    end
    step();
    m_drop = 1'b0;
    #1;
    checks++;
    if ({proto_err, rsp_valid, rsp_res, rsp_tag} !==
        {2'b11, fn(2'd1, a, b), 4'd9}) begin
      fails++;
      $display("FAIL perr_rise got %b/%b/%h/%0d want 1/1/%h/9",
               proto_err, rsp_valid, rsp_res, rsp_tag, fn(2'd1, a, b));
    end
    step();
    step();
    checks++;
    if (proto_err !== 1'b1) begin
      fails++; $display("FAIL perr_sticky got %b want 1", proto_err);
    end
  endtask

  task automatic test_reset_midflight();
    has = 4'hF;
    rsp_ready = 1'b1;
    drive(2'd0, $urandom, $urandom, 4'd10);
    step();
    drive(2'd2, $urandom, $urandom, 4'd11);
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({rsp_valid, used, proto_err} !== 5'd0) begin
        fails++;
        $display("FAIL rstmid c%0d got v=%b used=%0d perr=%b want 0/0/0",
                 k, rsp_valid, used, proto_err);
      end
      step();
    end
    drive(2'd0, 32'h3F800000, 32'h40000000, 4'd12);
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (rsp_valid !== (k == 3) ||
          (k == 3 && {rsp_res, rsp_tag} !== {32'h40400000, 4'd12})) begin
        fails++;
        $display("FAIL rstmid_new c%0d got %b/%h/%0d want %b/40400000/12",
                 k, rsp_valid, rsp_res, rsp_tag, k == 3);
      end
      step();
    end
  endtask

  task automatic test_random();
    int n_out;
    exp_t e;
    logic exp_v;
    q.delete();
    n_out = 0;
    for (int k = 0; k < 460; k++) begin
      if (k < 400) begin
        has         = 4'($urandom);
        fpu_d_ready = ($urandom_range(0, 7) != 0);
        rsp_ready   = ($urandom_range(0, 2) != 0);
        req_valid   = ($urandom_range(0, 3) != 0);
        req_mode    = 2'($urandom);
        req_lhs     = $urandom;
        req_rhs     = $urandom;
        req_tag     = 4'($urandom);
      end else begin
        fpu_d_ready = 1'b1;
        rsp_ready   = 1'b1;
        req_valid   = 1'b0;
      end
      #1;
      checks++;
      if (req_ready !== (fpu_d_ready && n_out < D) || used !== 3'(n_out)) begin
        fails++;
        $display("FAIL rnd_credit c%0d got rdy=%b used=%0d want %b/%0d",
                 k, req_ready, used, fpu_d_ready && n_out < D, n_out);
      end
      checks++;
      if (fpu_d_trig !== (req_valid && req_ready && has[req_mode])) begin
        fails++;
        $display("FAIL rnd_trig c%0d got %b", k, fpu_d_trig);
      end
      exp_v = (q.size() > 0) && (q[0].due <= cyc);
      checks++;
      if (rsp_valid !== exp_v) begin
        fails++;
        $display("FAIL rnd_valid c%0d got %b want %b", k, rsp_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if ({rsp_res, rsp_tag, rsp_err} !== {q[0].res, q[0].tag, q[0].err}) begin
          fails++;
          $display("FAIL rnd_rsp c%0d got %h/%0d/%b want %h/%0d/%b", k,
                   rsp_res, rsp_tag, rsp_err, q[0].res, q[0].tag, q[0].err);
        end
      end
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        void'(q.pop_front());
        n_out--;
      end
      if (req_valid && req_ready) begin
        e.tag = req_tag;
        e.err = !has[req_mode];
        e.res = has[req_mode] ? fn(req_mode, req_lhs, req_rhs) : 32'h0;
        e.due = cyc + L + 1;
        q.push_back(e);
        n_out++;
      end
      step();
    end
    checks++;
    if (q.size() != 0 || proto_err !== 1'b0) begin
      fails++;
      $display("FAIL rnd_drain got left=%0d perr=%b want 0/0", q.size(), proto_err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_unsupported();
    test_backpressure();
    test_proto_err();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
